sfm_streamer_arbiter: RTL

Parametrised N-channel TCDM arbiter for the softmax streamer. It merges `NB_CHAN` load/store channels onto one TCDM master port, arbitrates them in round-robin or fixed-priority mode, and routes in-order read responses back to the channel that issued each load. An ID FIFO bounds the number of outstanding loads, and store responses are never forwarded. The block replaces the fixed two-level mux/FIFO/filter chain between the source/sink channels and the streamer's TCDM port.

---
 rtl/sfm_streamer_arbiter.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sfm_streamer_arbiter.sv
// -----------------------------------------------------------------------------
// sfm_streamer_arbiter
//
// Merges NB_CHAN load/store channels onto a single TCDM master port for the
// softmax streamer. Channels are arbitrated round-robin (ARB_MODE=0) or with
// fixed priority, lowest index first (ARB_MODE=1). Every granted load pushes
// the issuing channel index into an ID FIFO. In-order read responses pop that
// FIFO and are steered back to the channel that issued the load. Store
// responses never come back from the memory side, so stores never push.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clear_i          synchronous clear, same effect as reset
//   enable_i         gates new grants; responses keep flowing
//   ch_*_i / ch_*_o  per-channel request, grant and response signals
//   tcdm_*_o/_i      TCDM master request, grant and response
//   outst_o          number of loads currently waiting for a response
//   err_o            sticky flag: a response arrived with no load outstanding
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sfm_streamer_arbiter #(
    parameter int unsigned NB_CHAN   = 4,
    parameter int unsigned DW        = 128,
    parameter int unsigned AW        = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned ARB_MODE  = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                enable_i,
    input  logic [NB_CHAN-1:0]                  ch_req_i,
    output logic [NB_CHAN-1:0]                  ch_gnt_o,
    input  logic [NB_CHAN-1:0]                  ch_wen_i,
    input  logic [NB_CHAN-1:0][AW-1:0]          ch_add_i,
    input  logic [NB_CHAN-1:0][DW/8-1:0]        ch_be_i,
    input  logic [NB_CHAN-1:0][DW-1:0]          ch_data_i,
    output logic [DW-1:0]                       ch_r_data_o,
    output logic [NB_CHAN-1:0]                  ch_r_valid_o,
    output logic                                tcdm_req_o,
    output logic                                tcdm_wen_o,
    output logic [AW-1:0]                       tcdm_add_o,
    output logic [DW/8-1:0]                     tcdm_be_o,
    output logic [DW-1:0]                       tcdm_data_o,
    input  logic                                tcdm_gnt_i,
    input  logic [DW-1:0]                       tcdm_r_data_i,
    input  logic                                tcdm_r_valid_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]      outst_o,
    output logic                                err_o
);

    localparam int unsigned IDW  = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;
    localparam int unsigned IDW1 = IDW + 1;
    localparam int unsigned PW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CW   = $clog2(MAX_OUTST + 1);

    // Channel index to one-hot channel vector.
    function automatic logic [NB_CHAN-1:0] id_to_onehot(input logic [IDW-1:0] id);
        return NB_CHAN'(1'b1) << id;
    endfunction

    // Next channel index, wrapping at NB_CHAN (NB_CHAN need not be a power of 2).
    function automatic logic [IDW-1:0] next_chan(input logic [IDW-1:0] id);
        logic [IDW-1:0] nxt;
        if (id == IDW'(NB_CHAN - 1)) begin
            nxt = {IDW{1'b0}};
        end else begin
            nxt = id + IDW'(1'b1);
        end
        return nxt;
    endfunction

    // Next FIFO pointer, wrapping at MAX_OUTST (need not be a power of 2).
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(MAX_OUTST - 1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1'b1);
        end
        return nxt;
    endfunction

    logic [IDW-1:0]  rr_r;
    logic [IDW-1:0]  fifo_mem_r [MAX_OUTST];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   cnt_r;
    logic            err_r;

    logic [NB_CHAN-1:0] elig_s;
    logic               full_s;
    logic               empty_s;
    logic               any_s;
    logic [IDW-1:0]     winner_s;
    logic [IDW:0]       rot_idx_s;
    logic               hs_s;
    logic               push_s;
    logic               pop_s;
    logic [IDW-1:0]     head_s;

    // FIFO status from the registered count only: a same-cycle pop never frees a slot early.
    always_comb begin
        full_s  = (cnt_r == CW'(MAX_OUTST));
        empty_s = (cnt_r == {CW{1'b0}});
    end

    // A full ID FIFO blocks loads but lets stores through.
    always_comb begin
        elig_s = ch_req_i & {NB_CHAN{enable_i}} & (~ch_wen_i | {NB_CHAN{~full_s}});
    end

    // Winner selection: rotating search from rr_r, or lowest eligible index.
    always_comb begin
        any_s     = 1'b0;
        winner_s  = {IDW{1'b0}};
        rot_idx_s = {IDW1{1'b0}};
        if (ARB_MODE == 1) begin
            for (int i = NB_CHAN - 1; i >= 0; i--) begin
                if (elig_s[i]) begin
                    any_s    = 1'b1;
                    winner_s = IDW'(i);
                end else begin
                    any_s    = any_s;
                end
            end
        end else begin
            for (int k = 0; k < NB_CHAN; k++) begin
                rot_idx_s = {1'b0, rr_r} + IDW1'(k);
                if (rot_idx_s >= IDW1'(NB_CHAN)) begin
                    rot_idx_s = rot_idx_s - IDW1'(NB_CHAN);
                end else begin
                    rot_idx_s = rot_idx_s;
                end
                if (!any_s && elig_s[rot_idx_s[IDW-1:0]]) begin
                    any_s    = 1'b1;
                    winner_s = rot_idx_s[IDW-1:0];
                end else begin
                    any_s    = any_s;
                end
            end
        end
    end

    // Master request mux; fields are zeroed when nothing is requested.
    always_comb begin
        tcdm_req_o  = any_s;
        tcdm_wen_o  = 1'b0;
        tcdm_add_o  = {AW{1'b0}};
        tcdm_be_o   = {(DW/8){1'b0}};
        tcdm_data_o = {DW{1'b0}};
        if (any_s) begin
            tcdm_wen_o  = ch_wen_i[winner_s];
            tcdm_add_o  = ch_add_i[winner_s];
            tcdm_be_o   = ch_be_i[winner_s];
            tcdm_data_o = ch_data_i[winner_s];
        end else begin
            tcdm_wen_o  = 1'b0;
        end
    end

    // Grant forwarding and handshake qualification.
    always_comb begin
        hs_s   = any_s & tcdm_gnt_i;
        push_s = hs_s & tcdm_wen_o;
        if (hs_s) begin
            ch_gnt_o = id_to_onehot(winner_s);
        end else begin
            ch_gnt_o = {NB_CHAN{1'b0}};
        end
    end

    // Response steering from the registered FIFO head; data is broadcast.
    always_comb begin
        head_s      = fifo_mem_r[rd_ptr_r];
        pop_s       = tcdm_r_valid_i & ~empty_s;
        ch_r_data_o = tcdm_r_data_i;
        if (pop_s) begin
            ch_r_valid_o = id_to_onehot(head_s);
        end else begin
            ch_r_valid_o = {NB_CHAN{1'b0}};
        end
    end

    // Round-robin pointer: moves past the winner only on a handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_r <= {IDW{1'b0}};
        end else if (clear_i) begin
            rr_r <= {IDW{1'b0}};
        end else if (hs_s) begin
            rr_r <= next_chan(winner_s);
        end
    end

    // ID FIFO: storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_mem_r[i] <= {IDW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (clear_i) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_mem_r[i] <= {IDW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= winner_s;
                wr_ptr_r             <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Sticky error: a response with nothing outstanding (e.g. stale after a clear).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (clear_i) begin
            err_r <= 1'b0;
        end else if (tcdm_r_valid_i && empty_s) begin
            err_r <= 1'b1;
        end
    end

    assign outst_o = cnt_r;
    assign err_o   = err_r;

endmodule
